// File: rtl/clock_pkg.sv
// Shared encodings for the digital clock: mode values, blank-mask bit positions,
// and the helper that maps the selected field to its blank bit.
package clock_pkg;

    localparam logic [1:0] MODE_RUN   = 2'd0;
    localparam logic [1:0] MODE_SET_H = 2'd1;
    localparam logic [1:0] MODE_SET_M = 2'd2;
    localparam logic [1:0] MODE_SET_S = 2'd3;

    localparam int unsigned BLANK_SEC  = 0;
    localparam int unsigned BLANK_MIN  = 1;
    localparam int unsigned BLANK_HOUR = 2;

    typedef enum logic [1:0] {
        StRun  = MODE_RUN,
        StSetH = MODE_SET_H,
        StSetM = MODE_SET_M,
        StSetS = MODE_SET_S
    } mode_e;

    function automatic logic [2:0] blank_mask(input mode_e m, input logic on);
        logic [2:0] mask;
        mask = '0;
        unique case (m)
            StSetH:  mask[BLANK_HOUR] = on;
            StSetM:  mask[BLANK_MIN]  = on;
            StSetS:  mask[BLANK_SEC]  = on;
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Increment-key front end: rising-edge detect plus hold-to-repeat paced by tick_fast.
// A clear (mode change) disarms repeating until the key is released and pressed again.
module key_repeat
    import clock_pkg::*;
#(
    parameter int unsigned RPT_DELAY = 2
) (
    input  logic clk_i,
    input  logic cr_ni,
    input  logic key_i,
    input  logic tick_fast_i,
    input  logic clr_i,
    output logic rise_o,
    output logic step_o
);

    localparam logic [3:0] RptLimit = 4'(RPT_DELAY);

    logic       key_q, key_d;
    logic       armed_q, armed_d;
    logic [3:0] cnt_q, cnt_d;
    logic       held;
    logic       rpt;

    always_comb begin
        key_d   = key_i;
        armed_d = armed_q;
        cnt_d   = cnt_q;
        rise_o  = key_i & ~key_q;
        held    = key_i & key_q;
        rpt     = held & armed_q & tick_fast_i & (cnt_q == RptLimit);

        if (clr_i || !key_i) begin
            armed_d = 1'b0;
            cnt_d   = '0;
        end else if (rise_o) begin
            armed_d = 1'b1;
            cnt_d   = '0;
        end else if (held && armed_q && tick_fast_i && (cnt_q != RptLimit)) begin
            cnt_d = cnt_q + 4'd1;
        end

        step_o = rise_o | rpt;
    end

    always_ff @(posedge clk_i) begin
        if (!cr_ni) begin
            key_q   <= 1'b0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            key_q   <= key_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode sequencer for the digital clock: ripple-carry enables in RUN, field stepping
// with auto-repeat and blink blanking in the SET modes. All outputs registered.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned RPT_DELAY = 2
) (
    input  logic       clk,
    input  logic       cr,
    input  logic       tick,
    input  logic       tick_fast,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       sec_co,
    input  logic       min_co,
    output logic       sec_en,
    output logic       min_en,
    output logic       hour_en,
    output logic       sec_cr,
    output logic [1:0] mode,
    output logic [2:0] blank
);

    mode_e      state_q, state_d;
    logic       blink_q, blink_d;
    logic       sec_en_q, sec_en_d;
    logic       min_en_q, min_en_d;
    logic       hour_en_q, hour_en_d;
    logic       sec_cr_q, sec_cr_d;
    logic [2:0] blank_q, blank_d;
    logic       inc_rise;
    logic       inc_step;
    logic       inc_ok;

    key_repeat #(
        .RPT_DELAY(RPT_DELAY)
    ) u_key_repeat (
        .clk_i      (clk),
        .cr_ni      (cr),
        .key_i      (key_inc),
        .tick_fast_i(tick_fast),
        .clr_i      (key_mode),
        .rise_o     (inc_rise),
        .step_o     (inc_step)
    );

    always_comb begin
        state_d   = state_q;
        blink_d   = blink_q;
        sec_en_d  = 1'b0;
        min_en_d  = 1'b0;
        hour_en_d = 1'b0;
        sec_cr_d  = 1'b1;
        // A mode change always wins over a same-cycle increment.
        inc_ok    = ~key_mode;

        if (key_mode) begin
            unique case (state_q)
                StRun:   state_d = StSetH;
                StSetH:  state_d = StSetM;
                StSetM:  state_d = StSetS;
                StSetS:  state_d = StRun;
                default: state_d = StRun;
            endcase
        end

        if (key_mode) begin
            blink_d = 1'b0;
        end else if ((state_q != StRun) && tick_fast) begin
            blink_d = ~blink_q;
        end

        unique case (state_q)
            StRun: begin
                sec_en_d  = tick;
                min_en_d  = tick & sec_co;
                hour_en_d = tick & sec_co & min_co;
            end
            StSetH:  hour_en_d = inc_step & inc_ok;
            StSetM:  min_en_d  = inc_step & inc_ok;
            StSetS:  sec_cr_d  = ~(inc_rise & inc_ok);
            default: sec_cr_d  = 1'b1;
        endcase

        blank_d = blank_mask(state_d, blink_d & ~key_inc);
    end

    always_ff @(posedge clk) begin
        if (!cr) begin
            state_q   <= StRun;
            blink_q   <= 1'b0;
            sec_en_q  <= 1'b0;
            min_en_q  <= 1'b0;
            hour_en_q <= 1'b0;
            sec_cr_q  <= 1'b1;
            blank_q   <= '0;
        end else begin
            state_q   <= state_d;
            blink_q   <= blink_d;
            sec_en_q  <= sec_en_d;
            min_en_q  <= min_en_d;
            hour_en_q <= hour_en_d;
            sec_cr_q  <= sec_cr_d;
            blank_q   <= blank_d;
        end
    end

    assign sec_en  = sec_en_q;
    assign min_en  = min_en_q;
    assign hour_en = hour_en_q;
    assign sec_cr  = sec_cr_q;
    assign mode    = state_q;
    assign blank   = blank_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed vector table, then random stimulus against
// a cycle-level behavioural model of the mode/enable/blink rules.
module tb_clock_mode_ctrl;

    localparam int unsigned RPT = 2;

    logic       clk = 1'b0;
    logic       cr, tick, tick_fast, key_mode, key_inc, sec_co, min_co;
    logic       sec_en, min_en, hour_en, sec_cr;
    logic [1:0] mode;
    logic [2:0] blank;

    clock_mode_ctrl #(
        .RPT_DELAY(RPT)
    ) dut (
        .clk      (clk),
        .cr       (cr),
        .tick     (tick),
        .tick_fast(tick_fast),
        .key_mode (key_mode),
        .key_inc  (key_inc),
        .sec_co   (sec_co),
        .min_co   (min_co),
        .sec_en   (sec_en),
        .min_en   (min_en),
        .hour_en  (hour_en),
        .sec_cr   (sec_cr),
        .mode     (mode),
        .blank    (blank)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cr, tk, tf, km, ki, sc, mc;
        logic [2:0] en;   // {hour, min, sec}
        logic       scr;
        logic [1:0] md;
        logic [2:0] bl;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    // Behavioural model state
    int m_mode  = 0;
    bit m_prev  = 0;
    bit m_valid = 0;
    int m_cnt   = 0;
    bit m_phase = 0;

    task automatic add(input logic c, input logic tk, input logic tf, input logic km,
                       input logic ki, input logic sc, input logic mc, input logic [2:0] en,
                       input logic scr, input logic [1:0] md, input logic [2:0] bl);
        vec_t v;
        v.cr = c; v.tk = tk; v.tf = tf; v.km = km; v.ki = ki; v.sc = sc; v.mc = mc;
        v.en = en; v.scr = scr; v.md = md; v.bl = bl;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s #%0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Expected registered outputs after the edge that samples v.
    task automatic model(input vec_t v, output logic [2:0] en, output logic scr,
                         output logic [1:0] md, output logic [2:0] bl);
        bit rise, incr;
        en  = 3'b000;
        scr = 1'b1;
        if (!v.cr) begin
            m_mode = 0; m_prev = 0; m_valid = 0; m_cnt = 0; m_phase = 0;
            md = 2'd0; bl = 3'b000;
            return;
        end
        rise = v.ki && !m_prev;
        incr = 0;
        if (rise) begin
            m_valid = 1; m_cnt = 0; incr = 1;
        end else if (v.ki && m_valid && v.tf) begin
            m_cnt++;
            incr = (m_cnt > RPT);
        end
        if (!v.ki) begin m_valid = 0; m_cnt = 0; end
        if (v.km) begin incr = 0; m_valid = 0; end
        case (m_mode)
            0: en = {v.tk & v.sc & v.mc, v.tk & v.sc, v.tk};
            1: en[2] = incr;
            2: en[1] = incr;
            default: scr = !(rise && !v.km);
        endcase
        if (v.km) m_phase = 0;
        else if (m_mode != 0 && v.tf) m_phase = !m_phase;
        if (v.km) m_mode = (m_mode + 1) % 4;
        md = 2'(m_mode);
        bl = (m_mode != 0 && m_phase && !v.ki) ? 3'(1 << (3 - m_mode)) : 3'b000;
        m_prev = v.ki;
    endtask

    task automatic apply(input vec_t v, input int idx, input bit use_table);
        logic [2:0] e_en, e_bl;
        logic       e_scr;
        logic [1:0] e_md;
        cr = v.cr; tick = v.tk; tick_fast = v.tf; key_mode = v.km;
        key_inc = v.ki; sec_co = v.sc; min_co = v.mc;
        model(v, e_en, e_scr, e_md, e_bl);
        @(posedge clk);
        #1;
        if (use_table) begin
            chk("tbl_en", idx, {5'd0, hour_en, min_en, sec_en}, {5'd0, v.en});
            chk("tbl_sec_cr", idx, {7'd0, sec_cr}, {7'd0, v.scr});
            chk("tbl_mode", idx, {6'd0, mode}, {6'd0, v.md});
            chk("tbl_blank", idx, {5'd0, blank}, {5'd0, v.bl});
        end
        chk("mdl_en", idx, {5'd0, hour_en, min_en, sec_en}, {5'd0, e_en});
        chk("mdl_sec_cr", idx, {7'd0, sec_cr}, {7'd0, e_scr});
        chk("mdl_mode", idx, {6'd0, mode}, {6'd0, e_md});
        chk("mdl_blank", idx, {5'd0, blank}, {5'd0, e_bl});
    endtask

    initial begin
        vec_t v;
        cr = 0; tick = 0; tick_fast = 0; key_mode = 0; key_inc = 0; sec_co = 0; min_co = 0;

        //   cr tk tf km ki sc mc   en      scr md  blank
        // Reset, RUN carries
        add(0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 3'b000);
        add(0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 3'b000);
        add(1, 1, 0, 0, 0, 1, 1, 3'b111, 1, 0, 3'b000);
        add(1, 0, 0, 0, 0, 1, 1, 3'b000, 1, 0, 3'b000);
        add(1, 1, 0, 0, 0, 1, 0, 3'b011, 1, 0, 3'b000);
        add(1, 1, 0, 0, 0, 0, 1, 3'b001, 1, 0, 3'b000);
        // SET_H: frozen, blink, single increment, press forces unblank
        add(1, 0, 0, 1, 0, 0, 0, 3'b000, 1, 1, 3'b000);
        for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 0, 1, 1, 3'b000, 1, 1, 3'b000);
        add(1, 0, 1, 0, 0, 0, 0, 3'b000, 1, 1, 3'b100);
        add(1, 0, 1, 0, 0, 0, 0, 3'b000, 1, 1, 3'b000);
        add(1, 0, 1, 0, 0, 0, 0, 3'b000, 1, 1, 3'b100);
        add(1, 0, 1, 0, 0, 0, 0, 3'b000, 1, 1, 3'b000);
        add(1, 0, 1, 0, 0, 0, 0, 3'b000, 1, 1, 3'b100);
        add(1, 0, 0, 0, 1, 0, 0, 3'b100, 1, 1, 3'b000);
        add(1, 0, 0, 0, 1, 0, 0, 3'b000, 1, 1, 3'b000);
        add(1, 0, 0, 0, 0, 0, 0, 3'b000, 1, 1, 3'b100);
        // key_mode together with a key_inc edge: mode wins, held key stays inert
        add(1, 0, 0, 1, 1, 0, 0, 3'b000, 1, 2, 3'b000);
        add(1, 0, 0, 0, 1, 0, 0, 3'b000, 1, 2, 3'b000);
        add(1, 0, 1, 0, 1, 0, 0, 3'b000, 1, 2, 3'b000);
        add(1, 0, 0, 0, 0, 0, 0, 3'b000, 1, 2, 3'b010);
        // SET_M press-and-hold: edge, then repeats on 3rd..6th tick_fast
        add(1, 0, 0, 0, 1, 0, 0, 3'b010, 1, 2, 3'b000);
        add(1, 0, 1, 0, 1, 0, 0, 3'b000, 1, 2, 3'b000);
        add(1, 0, 0, 0, 1, 0, 0, 3'b000, 1, 2, 3'b000);
        add(1, 0, 1, 0, 1, 0, 0, 3'b000, 1, 2, 3'b000);
        add(1, 0, 1, 0, 1, 0, 0, 3'b010, 1, 2, 3'b000);
        add(1, 0, 1, 0, 1, 0, 0, 3'b010, 1, 2, 3'b000);
        add(1, 0, 0, 0, 1, 0, 0, 3'b000, 1, 2, 3'b000);
        add(1, 0, 1, 0, 1, 0, 0, 3'b010, 1, 2, 3'b000);
        add(1, 0, 1, 0, 1, 0, 0, 3'b010, 1, 2, 3'b000);
        // Reset mid-set with key held
        add(0, 0, 0, 0, 1, 0, 0, 3'b000, 1, 0, 3'b000);
        add(1, 0, 0, 0, 1, 0, 0, 3'b000, 1, 0, 3'b000);
        add(1, 0, 0, 0, 1, 0, 0, 3'b000, 1, 0, 3'b000);
        // To SET_S: single sec_cr pulse, no repeat
        add(1, 0, 0, 1, 0, 0, 0, 3'b000, 1, 1, 3'b000);
        add(1, 0, 0, 1, 0, 0, 0, 3'b000, 1, 2, 3'b000);
        add(1, 0, 0, 1, 0, 0, 0, 3'b000, 1, 3, 3'b000);
        add(1, 0, 0, 0, 1, 0, 0, 3'b000, 0, 3, 3'b000);
        for (int i = 0; i < 8; i++) add(1, 0, 1, 0, 1, 0, 0, 3'b000, 1, 3, 3'b000);
        add(1, 0, 0, 0, 0, 0, 0, 3'b000, 1, 3, 3'b000);
        add(1, 0, 1, 0, 0, 0, 0, 3'b000, 1, 3, 3'b001);
        add(1, 0, 0, 1, 0, 0, 0, 3'b000, 1, 0, 3'b000);
        // key_mode with tick in RUN: enables still issued
        add(1, 1, 0, 1, 0, 0, 0, 3'b001, 1, 1, 3'b000);
        add(1, 0, 0, 1, 0, 0, 0, 3'b000, 1, 2, 3'b000);
        for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 0, 1, 1, 3'b000, 1, 2, 3'b000);
        add(1, 0, 0, 1, 0, 0, 0, 3'b000, 1, 3, 3'b000);
        for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 0, 1, 1, 3'b000, 1, 3, 3'b000);
        add(1, 0, 0, 1, 0, 0, 0, 3'b000, 1, 0, 3'b000);

        #2;
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i, 1'b1);

        // Random phase against the model
        v = vecs[0];
        v.ki = 0;
        for (int i = 0; i < 3000; i++) begin
            v.cr = ($urandom_range(0, 99) != 0);
            v.tk = ($urandom_range(0, 7) == 0);
            v.tf = !v.tk && ($urandom_range(0, 2) == 0);
            v.km = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 11) == 0) v.ki = !v.ki;
            v.sc = 1'($urandom_range(0, 1));
            v.mc = 1'($urandom_range(0, 1));
            apply(v, i, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_mode_ctrl.md
# clock_mode_ctrl

Mode and count-enable sequencer for the digital clock. It sits between the 1 Hz/fast tick generator and the cascaded seconds (counter60), minutes (counter60) and hours (counter24) counters. In RUN mode it drives ripple-carry enables. In the three SET modes it freezes time, steps the selected field from the increment key with auto-repeat, and generates the display blanking mask.

## Interface
- RPT_DELAY, 2, number of tick_fast pulses key_inc must be held before auto-repeat starts (1..15)
- clk  in  1  system clock
- cr  in  1  synchronous active-low reset
- tick  in  1  1 Hz timebase, single-cycle pulse
- tick_fast  in  1  4 Hz timebase, single-cycle pulse; never coincident with tick
- key_mode  in  1  debounced mode key, single-cycle pulse
- key_inc  in  1  debounced increment key, level (high while held)
- sec_co  in  1  seconds counter at terminal count (59), combinational from counter
- min_co  in  1  minutes counter at terminal count (59)
- sec_en  out  1  seconds count enable, single-cycle
- min_en  out  1  minutes count enable, single-cycle
- hour_en  out  1  hours count enable, single-cycle
- sec_cr  out  1  active-low seconds clear, single-cycle low pulse
- mode  out  2  current mode: 0 RUN, 1 SET_H, 2 SET_M, 3 SET_S
- blank  out  3  display blank mask {hour, min, sec}; 1 = field blanked

## Operation
- FSM: RUN -> SET_H -> SET_M -> SET_S -> RUN, advancing on each key_mode pulse. No other transitions.
- RUN:
  - tick produces sec_en.
  - tick & sec_co produces min_en.
  - tick & sec_co & min_co produces hour_en.
  - key_inc is ignored; blank = 0.
- SET modes:
  - tick is ignored and time is frozen.
  - Carries are never propagated; the selected field wraps by itself.
- Increment (SET_H/SET_M):
  - A rising edge of key_inc gives one hour_en/min_en pulse.
  - While the key is held, the controller counts tick_fast. After RPT_DELAY pulses it emits one enable per further tick_fast until release.
  - Release clears the repeat counter.
- SET_S: a rising edge of key_inc gives one sec_cr low pulse. No auto-repeat.
- Blink:
  - blink_phase toggles on each tick_fast in SET modes.
  - The selected field's blank bit = blink_phase & ~key_inc; all other bits are 0.
  - blink_phase clears on every mode change.
- Simultaneous events:
  - key_mode with a key_inc edge or repeat step: the mode change wins and the increment is dropped. Edge-detect history is still updated, so no increment fires on the next cycle.
  - key_mode with tick in RUN: the tick enables are still issued, and mode becomes SET_H.
  - key_mode while key_inc is held: the new field does not increment until key_inc is released and pressed again.
- Reset (cr=0 at a clock edge):
  - mode = RUN; sec_en = min_en = hour_en = 0; sec_cr = 1; blank = 0.
  - blink_phase, the repeat counter and key_inc history all clear.
  - Reset mid-set abandons the set with no pending increment.

## Timing
- All outputs are registered.
- Latency is 1 clk from tick, key_inc edge or tick_fast to the corresponding enable, sec_cr or blank change.
- sec_co/min_co are sampled in the tick cycle. The counters are unchanged until the registered enable, so the carries are consistent.
- mode updates 1 clk after key_mode.
- Enables are high for exactly 1 clk and at most one per field per cycle.
- Repeat rate is the tick_fast rate. The first repeat comes RPT_DELAY+1 tick_fast pulses after the press edge, counting the first tick_fast after the edge as 1.

## Structure
- Shared package clock_pkg holds:
  - mode encoding constants MODE_RUN/SET_H/SET_M/SET_S (2-bit);
  - blank-mask bit indices.
- Sub-module key_repeat contains:
  - key_inc edge detect;
  - the 4-bit repeat counter against RPT_DELAY;
  - a single-cycle step output, with clear input driven by mode change.
- The top level holds the FSM, enable decode, blink_phase and output registers.

## Test plan
- Reset and RUN carries:
  - Hold cr=0 for 2 clk → all enables 0, sec_cr=1, mode=0, blank=0.
  - Then tick with sec_co=1, min_co=1 → sec_en, min_en, hour_en all high 1 clk later, for exactly 1 clk.
- Mode cycling: 4 key_mode pulses → mode sequences 1,2,3,0. In each SET mode, 5 ticks give zero enables.
- SET_M press and hold with RPT_DELAY=2:
  - Edge → one min_en.
  - Hold through 6 tick_fast → 4 more min_en, on the 3rd–6th tick_fast.
  - sec_en and hour_en stay 0 throughout.
- SET_S: key_inc edge → sec_cr low exactly 1 clk; holding through 8 tick_fast → no further pulses.
- Blink in SET_H:
  - 4 tick_fast with key released → blank toggles 100,000,100,000.
  - Pressing key_inc forces blank=000.
- Simultaneous events and mid-set reset:
  - key_mode in the same cycle as a key_inc edge in SET_H → mode=2 and no hour_en.
  - cr=0 during SET_M with the key held → mode=0 and no enable after reset release.
